pag_refill_seq: RTL

Page-table refill sequencer for the paging board. When the PT lookup logic reports a miss (`pag4_page_refill_l` asserted), this block fetches the page-map word from the UPT or EPT in memory, checks it, writes it into the page table and PT directory, and then signals completion so the EBOX reference can retry. It is the writer side of the PT; the lookup/page-fail logic is the reader.

---
 rtl/pag_refill_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pag_refill_seq.sv
// Page-table refill sequencer: fetches a page-map word from the UPT/EPT on a PT miss,
// writes it into the PT and PT directory. Optional parity check: PAG_REFILL_PAR_CHK_EN.
module pag_refill_seq #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        pag4_page_refill_l,
    input  logic        refill_abort_h,
    input  logic [13:0] vma_13to26_h,
    input  logic        mcl_vma_user_h,
    input  logic [12:0] ubr_page_h,
    input  logic [12:0] ebr_page_h,
    output logic        mem_req_h,
    output logic [21:0] mem_adr_h,
    input  logic        mem_ack_h,
    input  logic        mem_data_valid_h,
    input  logic [35:0] mem_data_h,
    input  logic        mem_par_h,
    output logic [35:0] pt_wr_data_h,
    output logic [1:0]  pt_wr_sel_h,
    output logic        pt_wr_l,
    output logic        pt_dir_wr_l,
    output logic [5:0]  pt_dir_tag_h,
    output logic        refill_busy_h,
    output logic        refill_done_h,
    output logic        refill_error_h,
    output logic [1:0]  refill_err_code_h
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_CHECK, S_WRITE, S_DIR, S_DONE, S_ERR
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          par_err;
    logic          start, cap_data;
    logic [1:0]    err_code_d;

    // vma bit n sits at index 26-n: [13:9] dir tag, [8:1] map index, [0] half select.
    // Both halves are always written, so the half select is not needed here.
    logic unused_half;
    assign unused_half = vma_13to26_h[0];

`ifdef PAG_REFILL_PAR_CHK_EN
    logic par_q;
    // Odd parity over data+parity bit; an even result is an error.
    assign par_err = ~(^{pt_wr_data_h, par_q});
    always_ff @(posedge clk) begin
        if (!rst_l)
            par_q <= 1'b0;
        else if (cap_data)
            par_q <= mem_par_h;
    end
`else
    logic unused_par;
    assign unused_par = mem_par_h;
    assign par_err    = 1'b0;
`endif

    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_nx   = state;
        start      = 1'b0;
        cap_data   = 1'b0;
        err_code_d = refill_err_code_h;
        case (state)
            S_IDLE:  if (!pag4_page_refill_l && !refill_abort_h) begin
                         state_nx   = S_REQ;
                         start      = 1'b1;
                         err_code_d = 2'b00;
                     end
            S_REQ:   if (mem_ack_h)    state_nx = S_WAIT;
                     else if (tmo_hit) state_nx = S_ERR;
            S_WAIT:  if (mem_data_valid_h) begin
                         state_nx = S_CHECK;
                         cap_data = 1'b1;
                     end else if (tmo_hit) begin
                         state_nx = S_ERR;
                     end
            S_CHECK: state_nx = par_err ? S_ERR : S_WRITE;
            S_WRITE: state_nx = S_DIR;
            S_DIR:   state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (state_nx == S_ERR)
            err_code_d = (state == S_CHECK) ? 2'b01 : 2'b10;
        // Abort overrides every other transition and suppresses all captures.
        if (refill_abort_h && state != S_IDLE) begin
            state_nx   = S_IDLE;
            cap_data   = 1'b0;
            err_code_d = refill_err_code_h;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state             <= S_IDLE;
            tmo_cnt           <= '0;
            mem_req_h         <= 1'b0;
            mem_adr_h         <= '0;
            pt_wr_data_h      <= '0;
            pt_wr_sel_h       <= 2'b00;
            pt_wr_l           <= 1'b1;
            pt_dir_wr_l       <= 1'b1;
            pt_dir_tag_h      <= '0;
            refill_busy_h     <= 1'b0;
            refill_done_h     <= 1'b0;
            refill_error_h    <= 1'b0;
            refill_err_code_h <= 2'b00;
        end else begin
            state             <= state_nx;
            mem_req_h         <= (state_nx == S_REQ);
            pt_wr_l           <= (state_nx != S_WRITE);
            pt_wr_sel_h       <= (state_nx == S_WRITE) ? 2'b11 : 2'b00;
            pt_dir_wr_l       <= (state_nx != S_DIR);
            refill_busy_h     <= (state_nx != S_IDLE);
            refill_done_h     <= (state_nx == S_DONE);
            refill_error_h    <= (state_nx == S_ERR);
            refill_err_code_h <= err_code_d;
            if (start) begin
                tmo_cnt      <= '0;
                mem_adr_h    <= {mcl_vma_user_h ? ubr_page_h : ebr_page_h,
                                 ~mcl_vma_user_h, vma_13to26_h[8:1]};
                pt_dir_tag_h <= {mcl_vma_user_h, vma_13to26_h[13:9]};
            end else if (state == S_REQ || state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (cap_data)
                pt_wr_data_h <= mem_data_h;
        end
    end

endmodule
